// File: rtl/blink_rate_controller.sv
// Blink rate controller: turns button levels into single rate steps, holds a
// one-hot rate, and runs a prescaled countdown that toggles the light once per
// half-period at the selected rate.
module blink_rate_controller #(
  parameter int TICK_DIV    = 4,  // clocks per base tick
  parameter int PERIOD_UNIT = 2   // base ticks per half-period at fastest rate
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active low
  input  logic       enable,
  input  logic       shift_left,
  input  logic       shift_right,
  output logic       out_light,
  output logic [3:0] rate_state,
  output logic       toggle_pulse
);

  localparam int CNT_W = $clog2(PERIOD_UNIT * 8);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  // Countdown reload value for a one-hot rate: PERIOD_UNIT * 2^idx - 1.
  // An illegal (non one-hot) code falls back to the fastest rate's value.
  function automatic logic [CNT_W-1:0] load_of(input logic [3:0] rate);
    logic [CNT_W-1:0] val;
    case (rate)
      4'b0001: val = CNT_W'(PERIOD_UNIT * 1 - 1);
      4'b0010: val = CNT_W'(PERIOD_UNIT * 2 - 1);
      4'b0100: val = CNT_W'(PERIOD_UNIT * 4 - 1);
      4'b1000: val = CNT_W'(PERIOD_UNIT * 8 - 1);
      default: val = CNT_W'(PERIOD_UNIT - 1);
    endcase
    return val;
  endfunction

  logic             prev_l_r;
  logic             prev_r_r;
  logic [PRE_W-1:0] presc_r;
  logic [CNT_W-1:0] count_r;

  logic             step_l_s;
  logic             step_r_s;
  logic             tick_s;
  logic [CNT_W-1:0] load_s;
  logic [3:0]       rate_next_s;
  logic [PRE_W-1:0] presc_next_s;
  logic [CNT_W-1:0] count_next_s;
  logic             light_next_s;
  logic             pulse_next_s;

  // Rising-edge detection on the button levels and the base tick strobe.
  always_comb begin
    step_l_s = shift_left  & ~prev_l_r;
    step_r_s = shift_right & ~prev_r_r;
    tick_s   = (presc_r == PRE_LAST);
    load_s   = load_of(rate_state);
  end

  // Next rate: one saturating step per button edge; simultaneous edges cancel,
  // and any non one-hot code is forced back to the fastest rate.
  always_comb begin
    rate_next_s = rate_state;
    case (rate_state)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        if (step_l_s && !step_r_s) begin
          rate_next_s = rate_state[3] ? rate_state : {rate_state[2:0], 1'b0};
        end else if (step_r_s && !step_l_s) begin
          rate_next_s = rate_state[0] ? rate_state : {1'b0, rate_state[3:1]};
        end else begin
          rate_next_s = rate_state;
        end
      end
      default: rate_next_s = 4'b0001;
    endcase
  end

  // Next timer and light state: held at the start of a half-period while
  // disabled; otherwise prescale, count down, and toggle on expiry.
  always_comb begin
    presc_next_s = presc_r;
    count_next_s = count_r;
    light_next_s = out_light;
    pulse_next_s = 1'b0;
    if (!enable) begin
      presc_next_s = '0;
      count_next_s = load_s;
      light_next_s = 1'b0;
      pulse_next_s = 1'b0;
    end else begin
      if (tick_s) begin
        presc_next_s = '0;
      end else begin
        presc_next_s = presc_r + PRE_W'(1);
      end
      if (tick_s) begin
        if (count_r == '0) begin
          // Reload uses the currently registered rate, so a rate change
          // only takes effect from the next half-period.
          count_next_s = load_s;
          light_next_s = ~out_light;
          pulse_next_s = 1'b1;
        end else begin
          count_next_s = count_r - CNT_W'(1);
        end
      end else begin
        count_next_s = count_r;
      end
    end
  end

  // State and output registers with asynchronous return to power-up values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_l_r     <= 1'b0;
      prev_r_r     <= 1'b0;
      rate_state   <= 4'b0001;
      presc_r      <= '0;
      count_r      <= load_of(4'b0001);
      out_light    <= 1'b0;
      toggle_pulse <= 1'b0;
    end else begin
      prev_l_r     <= shift_left;
      prev_r_r     <= shift_right;
      rate_state   <= rate_next_s;
      presc_r      <= presc_next_s;
      count_r      <= count_next_s;
      out_light    <= light_next_s;
      toggle_pulse <= pulse_next_s;
    end
  end

endmodule

// File: tb/tb_blink_rate_controller.sv
// Directed bench for blink_rate_controller with default parameters
// (half-periods 8/16/32/64 clocks). Outputs are sampled 1 time unit after
// each rising edge; inputs change at the same point.
module tb_blink_rate_controller;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       shift_left;
  logic       shift_right;
  logic       out_light;
  logic [3:0] rate_state;
  logic       toggle_pulse;

  int checks   = 0;
  int failures = 0;

  blink_rate_controller #(.TICK_DIV(4), .PERIOD_UNIT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .shift_left   (shift_left),
    .shift_right  (shift_right),
    .out_light    (out_light),
    .rate_state   (rate_state),
    .toggle_pulse (toggle_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Advance until toggle_pulse is seen (bounded) and check the edge count.
  task automatic wait_toggle(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      step_clk();
      n++;
    end while (!toggle_pulse && n < 200);
    check(tag, 32'(n), 32'(exp));
  endtask

  // Advance to the next toggle whatever the distance; a timeout is a failure.
  task automatic skip_toggle(input string tag);
    int n;
    n = 0;
    do begin
      step_clk();
      n++;
    end while (!toggle_pulse && n < 200);
    check(tag, 32'(toggle_pulse), 32'd1);
  endtask

  task automatic pulse_left();
    shift_left = 1'b1;
    step_clk();
    shift_left = 1'b0;
    step_clk();
  endtask

  task automatic pulse_right();
    shift_right = 1'b1;
    step_clk();
    shift_right = 1'b0;
    step_clk();
  endtask

  logic [3:0] exp_rate;

  initial begin
    rst         = 1'b0;
    enable      = 1'b1;
    shift_left  = 1'b0;
    shift_right = 1'b0;

    // Reset state
    #12;
    check("rst_light", 32'(out_light), 32'd0);
    check("rst_rate", 32'(rate_state), 32'h1);
    check("rst_pulse", 32'(toggle_pulse), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // First two toggles at edges 8 and 16 after release
    for (int e = 1; e <= 16; e++) begin
      step_clk();
      check($sformatf("pu_light_e%0d", e), 32'(out_light), (e >= 8 && e < 16) ? 32'd1 : 32'd0);
      check($sformatf("pu_pulse_e%0d", e), 32'(toggle_pulse), (e == 8 || e == 16) ? 32'd1 : 32'd0);
    end
    check("pu_rate", 32'(rate_state), 32'h1);

    // Held shift_left mid-period: one step, current half-period unaffected
    repeat (3) step_clk();
    shift_left = 1'b1;
    step_clk();
    check("hold_rate_step", 32'(rate_state), 32'h2);
    wait_toggle("hold_cur_half", 4);
    wait_toggle("hold_next_half", 16);
    check("hold_rate_single", 32'(rate_state), 32'h2);
    shift_left = 1'b0;
    wait_toggle("hold_after_half", 16);

    // Step back to fastest, then four slower steps saturating at 1000
    pulse_right();
    check("r_to_1", 32'(rate_state), 32'h1);
    exp_rate = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      pulse_left();
      exp_rate = (exp_rate == 4'b1000) ? 4'b1000 : (exp_rate << 1);
      check($sformatf("left_pulse_%0d", i), 32'(rate_state), 32'(exp_rate));
    end
    skip_toggle("slow_sync");
    wait_toggle("slow_half", 64);

    // Five faster steps saturating at 0001
    for (int i = 0; i < 5; i++) begin
      pulse_right();
      exp_rate = (exp_rate == 4'b0001) ? 4'b0001 : (exp_rate >> 1);
      check($sformatf("right_pulse_%0d", i), 32'(rate_state), 32'(exp_rate));
    end
    check("right_final", 32'(rate_state), 32'h1);

    // Both buttons on the same edge: no change
    shift_left  = 1'b1;
    shift_right = 1'b1;
    step_clk();
    check("both_rate", 32'(rate_state), 32'h1);
    shift_left  = 1'b0;
    shift_right = 1'b0;
    skip_toggle("both_sync");
    wait_toggle("both_half", 8);
    check("both_rate_after", 32'(rate_state), 32'h1);

    // Disable mid-blink for 30 cycles with one slower step meanwhile
    repeat (3) step_clk();
    enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      shift_left = (i == 10) ? 1'b1 : 1'b0;
      step_clk();
      check($sformatf("dis_light_%0d", i), 32'(out_light), 32'd0);
      check($sformatf("dis_pulse_%0d", i), 32'(toggle_pulse), 32'd0);
    end
    shift_left = 1'b0;
    check("dis_rate", 32'(rate_state), 32'h2);
    enable = 1'b1;
    wait_toggle("en_first_rise", 16);
    check("en_light_high", 32'(out_light), 32'd1);

    // Reset asserted between edges mid-period
    repeat (3) step_clk();
    #2;
    rst = 1'b0;
    #1;
    check("async_light", 32'(out_light), 32'd0);
    check("async_rate", 32'(rate_state), 32'h1);
    repeat (2) step_clk();
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step_clk();
      check($sformatf("rr_light_e%0d", e), 32'(out_light), (e == 8) ? 32'd1 : 32'd0);
    end
    check("rr_pulse_e8", 32'(toggle_pulse), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blink_rate_controller.md
Name: blink_rate_controller

Overview:
Sequencer for the LED blinker datapath: turns shift_left/shift_right button levels into single rate steps, keeps a one-hot rate state, and runs a prescaled countdown that toggles the light at the selected rate. It combines rate stepping, period timing and toggle generation in one clocked controller. It sits between the board buttons and the LED pin.

Parameters:
TICK_DIV, 4, clocks per base tick (>=1; 1 = tick every cycle)
PERIOD_UNIT, 2, base ticks per half-period at the fastest rate (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
enable  input  1  1 = blinking runs; 0 = light off, timers held
shift_left  input  1  button level; rising edge = one step slower
shift_right  input  1  button level; rising edge = one step faster
out_light  output  1  blinking light, registered
rate_state  output  4  one-hot rate, 0001 fastest .. 1000 slowest
toggle_pulse  output  1  1-cycle strobe in the cycle out_light changes

Behaviour:
- Reset (rst=0, async): rate_state=0001, out_light=0, toggle_pulse=0, prescaler=0, countdown=LOAD(0001), button history regs=0.
- Edge detect: prev_l/prev_r registered each cycle. step_l = shift_left & ~prev_l; step_r = shift_right & ~prev_r. A held button gives exactly one step.
- Rate update (next edge after the step):
  - step_l only: shift left, saturating at 1000.
  - step_r only: shift right, saturating at 0001.
  - Both in the same cycle: no change.
  - rate_state is always exactly one-hot.
- LOAD(rate) = PERIOD_UNIT * 2^idx - 1, where idx = position of the set bit (0..3).
  - Countdown width = clog2(PERIOD_UNIT*8).
  - Prescaler width = max(1, clog2(TICK_DIV)).
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 combinationally while prescaler==TICK_DIV-1.
- Countdown on tick:
  - countdown==0: reload LOAD(rate_state as currently registered), toggle out_light, assert toggle_pulse for that one following cycle.
  - otherwise: decrement.
  - No tick: hold.
- A rate change never truncates the half-period in progress. It takes effect at the next reload.
- Half-period = PERIOD_UNIT*2^idx*TICK_DIV clocks. Defaults: 8, 16, 32, 64 clocks.
- enable=0:
  - Each cycle: prescaler=0, countdown=LOAD(rate_state), out_light=0, toggle_pulse=0.
  - Buttons are still tracked and still step the rate.
  - After enable returns to 1: first out_light rise occurs exactly one full half-period later.
- Reset asserted mid-period: immediate return to reset values regardless of clk. Release behaves as from power-up.
- out_light goes 1 exactly 8 rising clk edges after reset release (defaults, enable=1), then toggles every half-period.
- toggle_pulse is high in the cycle that out_light shows its new value.

Test Plan:
- Reset release, enable=1, defaults, no buttons -> out_light 0→1 at edge 8, 1→0 at edge 16; toggle_pulse high exactly those cycles; rate_state=0001.
- shift_left held high 20 cycles starting mid-period -> rate_state=0010 one edge after press (single step despite hold); current half-period still 8 clocks, following ones 16.
- Four separate shift_left pulses -> rate_state 0010, 0100, 1000, 1000 (saturated); half-period 64 clocks. Then five shift_right pulses -> ends at 0001.
- shift_left and shift_right rising on the same edge -> rate_state unchanged; timing unaffected.
- enable driven 0 for 30 cycles mid-blink, one shift_left pulse meanwhile -> out_light=0 throughout, rate_state steps to 0010; after enable=1, out_light rises exactly 16 clocks later.
- rst pulled low between clk edges mid-period -> out_light=0, rate_state=0001 immediately (before next edge); after release, first rise at edge 8.
